// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: opcode-type codes (Inst[6:2]) and instruction field positions.
package rv_pipe_pkg;

  localparam logic [4:0] LOAD_TYPE   = 5'b00000;
  localparam logic [4:0] STORE_TYPE  = 5'b01000;
  localparam logic [4:0] BRANCH_TYPE = 5'b11000;
  localparam logic [4:0] OP_TYPE     = 5'b01100;
  localparam logic [4:0] OP_IMM_TYPE = 5'b00100;
  localparam logic [4:0] LUI_TYPE    = 5'b01101;
  localparam logic [4:0] AUIPC_TYPE  = 5'b00101;
  localparam logic [4:0] JAL_TYPE    = 5'b11011;
  localparam logic [4:0] JALR_TYPE   = 5'b11001;

  localparam int unsigned RD_LSB   = 7;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned TYPE_LSB = 2;
  localparam int unsigned TYPE_MSB = 6;

  // Only stores and branches leave rd untouched; unknown types still write.
  function automatic logic writes_rd(input logic [4:0] op_type);
    return !((op_type == STORE_TYPE) || (op_type == BRANCH_TYPE));
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: async clear, one write port, two read ports bypassed from the write port.
module register_file
  import rv_pipe_pkg::*;
#(
  parameter int REG_COUNT  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // The write port carries the pending MEM/WB write, so it doubles as the bypass source.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wr_en && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wr_en && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: MEM/WB pipeline register, retired-instruction counter and the register file.
module register_writeback
  import rv_pipe_pkg::*;
#(
  parameter int REG_COUNT   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Valid_In,
  input  logic [31:0]            Inst_In,
  input  logic [DATA_WIDTH-1:0]  Register_Data_In,
  input  logic [ADDR_WIDTH-1:0]  Rs1_Addr_In,
  input  logic [ADDR_WIDTH-1:0]  Rs2_Addr_In,
  output logic [DATA_WIDTH-1:0]  Rs1_Data_Out,
  output logic [DATA_WIDTH-1:0]  Rs2_Data_Out,
  output logic                   Wb_En_Out,
  output logic [ADDR_WIDTH-1:0]  Wb_Rd_Out,
  output logic [DATA_WIDTH-1:0]  Wb_Data_Out,
  output logic [COUNT_WIDTH-1:0] Retired_Count_Out
);

  logic [ADDR_WIDTH-1:0] rd;
  logic [4:0]            op_type;
  logic                  capture_write;
  logic                  unused_inst;

  assign rd          = ADDR_WIDTH'(Inst_In[RD_MSB:RD_LSB]);
  assign op_type     = Inst_In[TYPE_MSB:TYPE_LSB];
  assign unused_inst = ^{Inst_In[31:12], Inst_In[1:0]};

  always_comb begin
    capture_write = Valid_In && writes_rd(op_type) && (rd != '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Wb_En_Out         <= 1'b0;
      Wb_Rd_Out         <= '0;
      Wb_Data_Out       <= '0;
      Retired_Count_Out <= '0;
    end else begin
      Wb_En_Out   <= capture_write;
      Wb_Rd_Out   <= rd;
      Wb_Data_Out <= Register_Data_In;
      if (Valid_In) begin
        Retired_Count_Out <= Retired_Count_Out + COUNT_WIDTH'(1);
      end
    end
  end

  register_file #(
    .REG_COUNT  (REG_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_register_file (
    .clk      (Clk),
    .rst      (Reset),
    .wr_en    (Wb_En_Out),
    .wr_addr  (Wb_Rd_Out),
    .wr_data  (Wb_Data_Out),
    .rs1_addr (Rs1_Addr_In),
    .rs2_addr (Rs2_Addr_In),
    .rs1_data (Rs1_Data_Out),
    .rs2_data (Rs2_Data_Out)
  );

endmodule

// File: tb/tb_register_writeback.sv
// Bench for register_writeback: directed vector table, reset corner cases, random traffic against a visible-state model.
module tb_register_writeback;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid_In;
  logic [31:0] Inst_In;
  logic [31:0] Register_Data_In;
  logic [4:0]  Rs1_Addr_In;
  logic [4:0]  Rs2_Addr_In;
  logic [31:0] Rs1_Data_Out;
  logic [31:0] Rs2_Data_Out;
  logic        Wb_En_Out;
  logic [4:0]  Wb_Rd_Out;
  logic [31:0] Wb_Data_Out;
  logic [31:0] Retired_Count_Out;

  // Narrow-counter instance, used only to observe the counter wrapping.
  logic [31:0] unused_rs1_w, unused_rs2_w, unused_data_w;
  logic        unused_en_w;
  logic [4:0]  unused_rd_w;
  logic [3:0]  count_w;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  register_writeback #(
    .REG_COUNT(32), .DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Valid_In(Valid_In), .Inst_In(Inst_In),
    .Register_Data_In(Register_Data_In), .Rs1_Addr_In(Rs1_Addr_In), .Rs2_Addr_In(Rs2_Addr_In),
    .Rs1_Data_Out(Rs1_Data_Out), .Rs2_Data_Out(Rs2_Data_Out), .Wb_En_Out(Wb_En_Out),
    .Wb_Rd_Out(Wb_Rd_Out), .Wb_Data_Out(Wb_Data_Out), .Retired_Count_Out(Retired_Count_Out)
  );

  register_writeback #(
    .REG_COUNT(32), .DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(4)
  ) dut_w (
    .Clk(Clk), .Reset(Reset), .Valid_In(Valid_In), .Inst_In(Inst_In),
    .Register_Data_In(Register_Data_In), .Rs1_Addr_In(Rs1_Addr_In), .Rs2_Addr_In(Rs2_Addr_In),
    .Rs1_Data_Out(unused_rs1_w), .Rs2_Data_Out(unused_rs2_w), .Wb_En_Out(unused_en_w),
    .Wb_Rd_Out(unused_rd_w), .Wb_Data_Out(unused_data_w), .Retired_Count_Out(count_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] model_regs [32];
  logic [31:0] model_count;
  logic [4:0]  op_types [9];

  initial begin
    vecs[0] = '{1'b1, 32'h00500193, 32'h5,        5'd3,  5'd0,  1'b1, 5'd3,  32'h5,        32'h5,    32'h0,    32'd1};
    vecs[1] = '{1'b0, 32'h00000000, 32'h0,        5'd3,  5'd3,  1'b0, 5'd0,  32'h0,        32'h5,    32'h5,    32'd1};
    vecs[2] = '{1'b1, 32'h00000223, 32'hDEAD,     5'd4,  5'd3,  1'b0, 5'd4,  32'hDEAD,     32'h0,    32'h5,    32'd2};
    vecs[3] = '{1'b1, 32'h00000013, 32'hFFFFFFFF, 5'd0,  5'd0,  1'b0, 5'd0,  32'hFFFFFFFF, 32'h0,    32'h0,    32'd3};
    vecs[4] = '{1'b1, 32'h00000383, 32'h11,       5'd3,  5'd7,  1'b1, 5'd7,  32'h11,       32'h5,    32'h11,   32'd4};
    vecs[5] = '{1'b1, 32'h00000383, 32'h22,       5'd3,  5'd7,  1'b1, 5'd7,  32'h22,       32'h5,    32'h22,   32'd5};
    vecs[6] = '{1'b0, 32'h00000000, 32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        32'h22,   32'h22,   32'd5};
    vecs[7] = '{1'b1, 32'h000003E3, 32'h99,       5'd7,  5'd4,  1'b0, 5'd7,  32'h99,       32'h22,   32'h0,    32'd6};
    vecs[8] = '{1'b1, 32'h0000057F, 32'h1234,     5'd10, 5'd0,  1'b1, 5'd10, 32'h1234,     32'h1234, 32'h0,    32'd7};
    vecs[9] = '{1'b1, 32'h000000EF, 32'h44,       5'd1,  5'd10, 1'b1, 5'd1,  32'h44,       32'h44,   32'h1234, 32'd8};

    op_types = '{5'b00000, 5'b01000, 5'b11000, 5'b01100, 5'b00100,
                 5'b01101, 5'b00101, 5'b11011, 5'b11001};

    Reset = 1'b0; Valid_In = 1'b0; Inst_In = '0; Register_Data_In = '0;
    Rs1_Addr_In = 5'd5; Rs2_Addr_In = 5'd0;
    #1 Reset = 1'b1;

    // Reset held while valid writes to x5 are offered.
    for (int i = 0; i < 3; i++) begin
      Valid_In = 1'b1; Inst_In = 32'h00500293; Register_Data_In = 32'hCAFE0000 + i;
      @(posedge Clk); #1;
      check("rst_wb_en", {31'b0, Wb_En_Out}, 32'h0);
      check("rst_wb_rd", {27'b0, Wb_Rd_Out}, 32'h0);
      check("rst_wb_data", Wb_Data_Out, 32'h0);
      check("rst_count", Retired_Count_Out, 32'h0);
      check("rst_rs1_x5", Rs1_Data_Out, 32'h0);
      Valid_In = 1'b0; #1;
    end
    Valid_In = 1'b0; Inst_In = '0; Register_Data_In = '0;
    @(negedge Clk); Reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      Valid_In = vecs[i].valid; Inst_In = vecs[i].inst; Register_Data_In = vecs[i].data;
      @(posedge Clk); #1;
      Rs1_Addr_In = vecs[i].rs1; Rs2_Addr_In = vecs[i].rs2; #1;
      check($sformatf("vec%0d_wb_en", i), {31'b0, Wb_En_Out}, {31'b0, vecs[i].exp_en});
      check($sformatf("vec%0d_wb_rd", i), {27'b0, Wb_Rd_Out}, {27'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d_wb_data", i), Wb_Data_Out, vecs[i].exp_wdata);
      check($sformatf("vec%0d_rs1", i), Rs1_Data_Out, vecs[i].exp_rs1);
      check($sformatf("vec%0d_rs2", i), Rs2_Data_Out, vecs[i].exp_rs2);
      check($sformatf("vec%0d_count", i), Retired_Count_Out, vecs[i].exp_count);
    end

    // Reset between capture and commit of x9 = 0xAB.
    Valid_In = 1'b1; Inst_In = 32'h00000483; Register_Data_In = 32'hAB;
    @(posedge Clk); #1;
    Rs1_Addr_In = 5'd9; #1;
    check("midrst_capture_en", {31'b0, Wb_En_Out}, 32'h1);
    check("midrst_bypass_x9", Rs1_Data_Out, 32'hAB);
    Valid_In = 1'b0; Inst_In = '0; Register_Data_In = '0;
    Reset = 1'b1; #1;
    check("midrst_async_en", {31'b0, Wb_En_Out}, 32'h0);
    check("midrst_async_x9", Rs1_Data_Out, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    Rs1_Addr_In = 5'd9; Rs2_Addr_In = 5'd1; #1;
    check("midrst_after_x9", Rs1_Data_Out, 32'h0);
    check("midrst_after_x1", Rs2_Data_Out, 32'h0);
    check("midrst_after_en", {31'b0, Wb_En_Out}, 32'h0);
    check("midrst_after_count", Retired_Count_Out, 32'h0);
    check("midrst_after_count_w", {28'b0, count_w}, 32'h0);

    // Random traffic: model holds what the read ports should show (writes visible from capture).
    for (int r = 0; r < 32; r++) model_regs[r] = '0;
    model_count = '0;
    for (int n = 0; n < 400; n++) begin
      logic        v;
      logic [4:0]  t;
      logic [4:0]  rdv;
      logic [31:0] d;
      logic        exp_en;
      v   = ($urandom_range(0, 3) != 0);
      t   = ($urandom_range(0, 9) == 9) ? 5'($urandom) : op_types[$urandom_range(0, 8)];
      rdv = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d   = $urandom;
      Valid_In = v; Inst_In = {20'($urandom), rdv, t, 2'b11}; Register_Data_In = d;
      exp_en = v && (t != 5'b01000) && (t != 5'b11000) && (rdv != 5'd0);
      @(posedge Clk); #1;
      if (exp_en) model_regs[rdv] = d;
      if (v) model_count = model_count + 1;
      Rs1_Addr_In = ($urandom_range(0, 1) == 0) ? rdv : 5'($urandom);
      Rs2_Addr_In = 5'($urandom); #1;
      check("rnd_wb_en", {31'b0, Wb_En_Out}, {31'b0, exp_en});
      check("rnd_wb_rd", {27'b0, Wb_Rd_Out}, {27'b0, rdv});
      check("rnd_wb_data", Wb_Data_Out, d);
      check("rnd_rs1", Rs1_Data_Out, model_regs[Rs1_Addr_In]);
      check("rnd_rs2", Rs2_Data_Out, model_regs[Rs2_Addr_In]);
      check("rnd_count", Retired_Count_Out, model_count);
      check("rnd_count_wrap", {28'b0, count_w}, model_count % 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Pipeline stage directly downstream of the data-memory stage.
- Captures the memory stage's instruction and result word (load data or bypassed ALU result) in a MEM/WB pipeline register. On the following edge it commits the result into the 32-entry architectural register file.
- Provides the decode stage's two combinational read ports, with write-through bypass, and exposes the pending write for forwarding.
- Counts retired instructions.

Parameters:
- REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero.
- DATA_WIDTH, 32, register and data word width.
- ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH == REG_COUNT.
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Valid_In  input  1  Inst_In and Register_Data_In are valid this cycle; low means bubble.
- Inst_In  input  32  instruction from the memory stage.
- Register_Data_In  input  DATA_WIDTH  load data or arithmetic/branch result from the memory stage.
- Rs1_Addr_In  input  ADDR_WIDTH  decode read port 1 index.
- Rs2_Addr_In  input  ADDR_WIDTH  decode read port 2 index.
- Rs1_Data_Out  output  DATA_WIDTH  read port 1 data (combinational).
- Rs2_Data_Out  output  DATA_WIDTH  read port 2 data (combinational).
- Wb_En_Out  output  1  MEM/WB register holds a write that commits on the next edge.
- Wb_Rd_Out  output  ADDR_WIDTH  destination index of the pending write.
- Wb_Data_Out  output  DATA_WIDTH  data of the pending write.
- Retired_Count_Out  output  COUNT_WIDTH  number of valid instructions retired.

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-operation:
  - All register-file entries are cleared to 0.
  - Wb_En_Out=0, Wb_Rd_Out=0, Wb_Data_Out=0, Retired_Count_Out=0.
  - A pending write is discarded and never commits.
- Instruction type is Inst_In[6:2]. Stores (5'b01000) and branches (5'b11000) do not write. All other types write: load 00000, OP 01100, OP-IMM 00100, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, and any unrecognised type.
- Capture at rising edge N:
  - Wb_En_Out <= Valid_In && writing type && rd != 0, where rd = Inst_In[11:7].
  - Wb_Rd_Out <= rd.
  - Wb_Data_Out <= Register_Data_In.
  - The stage is never stalled; it captures every edge.
- Commit at rising edge N+1: if Wb_En_Out is high, Regs[Wb_Rd_Out] <= Wb_Data_Out.
  - Latency from input to architectural state is 2 edges.
  - From edge N onward the value is visible on the read ports through the bypass.
- Read ports, for each of port 1 and port 2:
  - Index 0 returns 0.
  - Else, if Wb_En_Out is high and the index equals Wb_Rd_Out, return Wb_Data_Out (bypass).
  - Else return Regs[index].
- Back-to-back writes to the same rd: the younger write is in MEM/WB while the older one commits at the same edge. The read port returns the younger value. The array holds the younger value after the next edge.
- Writes to x0 are suppressed; Regs[0] stays 0.
- Retired_Count_Out increments by 1 on every edge where Valid_In=1, including stores and branches. It wraps modulo 2**COUNT_WIDTH.
- Bubbles (Valid_In=0) clear Wb_En_Out and do not count.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - opcode-type constants LOAD_TYPE, STORE_TYPE, BRANCH_TYPE, OP_TYPE, OP_IMM_TYPE, LUI_TYPE, AUIPC_TYPE, JAL_TYPE, JALR_TYPE;
  - instruction field slices RD_LSB=7, RD_MSB=11.
- One sub-module, register_file: array, asynchronous clear, single write port, two bypassed read ports. The pipeline register and counter stay in the top block.

Test Plan:
- Reset with Valid_In=1 toggling → all outputs 0; Rs1_Addr_In=5 reads 0; Retired_Count_Out stays 0 while Reset is high.
- ADDI rd=x3 (Inst_In=32'h00500193), Register_Data_In=32'h5 → after edge 1: Wb_En_Out=1, Wb_Rd_Out=3, Rs1 on x3 reads 5 via bypass. After edge 2: Wb_En_Out=0 and Rs1 still reads 5 (from the array).
- Store (opcode 0100011) with Inst_In[11:7]=4 and data 32'hDEAD → Wb_En_Out=0, x4 unchanged at 0, Retired_Count_Out increments by 1.
- Write to x0 with data 32'hFFFFFFFF → Wb_En_Out=0; both ports read x0 = 0.
- Back-to-back LOADs to x7 with data 32'h11 then 32'h22 → Rs2 on x7 reads 0x11 then 0x22; final array value is 0x22.
- Reset asserted between capture and commit of x9=32'hAB → x9 reads 0 after Reset is released; no late write.
